// File: rtl/trigger_capture.sv
// trigger_capture: keeps a circular pre-trigger history in local RAM, records
// a configured number of post-trigger samples once a trigger arrives, then
// replays the whole capture window oldest-first on an output stream.
module trigger_capture #(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int MAW = 10
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [1:0]     sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [SDW-1:0] sto_tdata,
  output logic [1:0]     sts_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

  localparam logic [1:0]     EV_START = 2'b01;
  localparam logic [1:0]     EV_TRIG  = 2'b10;
  localparam logic [1:0]     EV_ABORT = 2'b11;
  localparam logic [BAW-1:0] ADDR_PRE  = BAW'(0);
  localparam logic [BAW-1:0] ADDR_POST = BAW'(1);
  localparam logic [BAW-1:0] ADDR_CTRL = BAW'(2);
  localparam logic [MAW:0]   DEPTH     = {1'b1, {MAW{1'b0}}};
  localparam logic [MAW:0]   ONE       = (MAW+1)'(1);

  state_t state, state_next;

  logic [SDW-1:0] mem [0:(1<<MAW)-1];

  logic [MAW-1:0] cfg_pre;
  logic [MAW:0]   cfg_post;
  logic [MAW-1:0] wp;
  logic [MAW-1:0] fill;
  logic [MAW-1:0] rd_addr;
  logic [MAW:0]   rd_left;
  logic [MAW:0]   remain;

  logic           bus_arm, bus_abort;
  logic           in_xfer, ev_start, ev_trig, ev_abort;
  logic           abort_req, trig_latch, mem_we, rd_en, out_xfer;
  logic [MAW-1:0] mem_waddr;
  logic [MAW:0]   room, post_clip, total_calc, remain_calc;
  logic           unused_wdata;

  assign bus_wready   = 1'b1;
  assign unused_wdata = ^bus_wdata[BDW-1:MAW+1];

  assign bus_arm   = bus_wvalid && (bus_waddr == ADDR_CTRL) && bus_wdata[0];
  assign bus_abort = bus_wvalid && (bus_waddr == ADDR_CTRL) && bus_wdata[1];

  assign in_xfer  = sti_tvalid && sti_tready;
  assign ev_start = in_xfer && (sti_tevent == EV_START);
  assign ev_trig  = in_xfer && (sti_tevent == EV_TRIG);
  assign ev_abort = in_xfer && (sti_tevent == EV_ABORT);

  // Abort only means something while a capture is being recorded; it also
  // wins over a trigger arriving in the same cycle.
  assign abort_req  = ((state == ARMED) || (state == POST)) && (bus_abort || ev_abort);
  assign trig_latch = (state == ARMED) && ev_trig && !abort_req;

  // The arming sample of an event-started capture lands at address 0.
  assign mem_we    = ((state == IDLE) && ev_start) ||
                     (((state == ARMED) || (state == POST)) && in_xfer && !abort_req);
  assign mem_waddr = (state == IDLE) ? '0 : wp;

  // Post-trigger length is clipped so pre + post never exceeds the RAM depth.
  assign room        = DEPTH - {1'b0, fill};
  assign post_clip   = (cfg_post > room) ? room : cfg_post;
  assign total_calc  = {1'b0, fill} + post_clip;
  assign remain_calc = post_clip - ONE;

  assign out_xfer = sto_tvalid && sto_tready;
  assign rd_en    = (state == READOUT) && (rd_left != '0) && (!sto_tvalid || sto_tready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decision from bus strobes, sample events and readout progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus_arm || ev_start) state_next = ARMED;
      end
      ARMED: begin
        if (abort_req)       state_next = IDLE;
        else if (trig_latch) state_next = (remain_calc == '0) ? READOUT : POST;
      end
      POST: begin
        if (abort_req)                    state_next = IDLE;
        else if (mem_we && remain == ONE) state_next = READOUT;
      end
      READOUT: begin
        if (out_xfer && sto_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input is refused only while the capture window is being replayed.
  always_comb begin
    sti_tready = (state != READOUT);
    sts_state  = state;
  end

  // Configuration registers; post length of zero is promoted to one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pre  <= '0;
      cfg_post <= ONE;
    end else if (bus_wvalid) begin
      if (bus_waddr == ADDR_PRE)  cfg_pre <= bus_wdata[MAW-1:0];
      if (bus_waddr == ADDR_POST) cfg_post <= (bus_wdata[MAW:0] == '0) ? ONE : bus_wdata[MAW:0];
    end
  end

  // Write pointer, history fill, trigger latch and readout address bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      fill    <= '0;
      rd_addr <= '0;
      rd_left <= '0;
      remain  <= '0;
    end else begin
      if (state == IDLE) begin
        wp   <= mem_we ? MAW'(1) : '0;
        fill <= (mem_we && cfg_pre != '0) ? MAW'(1) : '0;
      end else if (mem_we) begin
        wp <= wp + 1'b1;
        if (fill < cfg_pre) fill <= fill + 1'b1;
      end

      if (trig_latch) begin
        rd_addr <= wp - fill;
        rd_left <= total_calc;
        remain  <= remain_calc;
      end else if ((state == POST) && mem_we) begin
        remain <= remain - ONE;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
        rd_left <= rd_left - ONE;
      end
    end
  end

  // Capture RAM write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= sti_tdata;
  end

  // Synchronous RAM read straight into the output register, refilled whenever
  // the current word leaves so the stream sustains one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
    end else if (rd_en) begin
      sto_tdata  <= mem[rd_addr];
      sto_tvalid <= 1'b1;
      sto_tlast  <= (rd_left == ONE);
    end else if (sto_tready) begin
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
    end
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Capture stage directly downstream of the trigger state machine. It consumes the trigger's sample stream (`tdata` plus 2-bit `tevent`) and keeps a circular pre-trigger history in a local RAM. On a trigger event it records a configured number of post-trigger samples, then replays the whole capture window, oldest sample first, on an output stream with a last-flag. Configuration is write-only over the same system bus as the trigger block.

## Interface

- `BDW`, 32, bus data width
- `BAW`, 6, bus address width
- `SDW`, 32, sample data width
- `MAW`, 10, capture memory address width; depth `2**MAW`
- `clk` in 1, clock; single clock domain
- `rst` in 1, reset; synchronous, active-high
- `bus_wready` out 1, constant 1
- `bus_wvalid` in 1, bus write valid
- `bus_waddr` in BAW, bus write address
- `bus_wdata` in BDW, bus write data
- `sti_tready` out 1, input ready
- `sti_tvalid` in 1, input valid
- `sti_tevent` in 2, input event code: 00 none, 01 start, 10 trigger, 11 abort
- `sti_tdata` in SDW, input sample
- `sto_tready` in 1, output ready
- `sto_tvalid` out 1, output valid
- `sto_tlast` out 1, marks the final sample of the capture
- `sto_tdata` out SDW, output sample
- `sts_state` out 2, current state: 0 IDLE, 1 ARMED, 2 POST, 3 READOUT

## Operation

- Register writes (bus transfer = `bus_wvalid`, which is always accepted):
  - addr 0: `cfg_pre[MAW-1:0]`, the number of pre-trigger samples. Reset value 0.
  - addr 1: `cfg_post[MAW:0]`, the number of post-trigger samples, including the trigger sample. Reset value 1; a written value of 0 is stored as 1.
  - addr 2: control. bit0 = arm, bit1 = abort. These are self-clearing strobes and are not stored.
  - Other addresses are ignored.
- Input transfer = `sti_tvalid & sti_tready`. `sti_tready` = 1 in IDLE, ARMED and POST; it is 0 in READOUT.
- IDLE:
  - Accepted samples are discarded.
  - A bus arm, or an accepted sample with event 01, moves the block to ARMED. In the event case that sample is stored as the first history sample.
  - On entry to ARMED: write pointer `wp` = 0, fill count `fill` = 0.
- ARMED:
  - Each accepted sample is written to `mem[wp]`; `wp` increments modulo `2**MAW`.
  - `fill` saturates at `cfg_pre`.
  - An accepted sample with event 10 is the trigger sample. It is written normally, and the block latches:
    - `rd_start = wp - fill`, the pre-window excluding the trigger sample, modulo depth
    - `total = fill + min(cfg_post, 2**MAW - fill)`
    - `remain = total - fill - 1`
  - If `remain` = 0, go to READOUT; otherwise go to POST.
- POST:
  - Each accepted sample is written and `remain` is decremented.
  - When the accepted sample makes `remain` reach 0, go to READOUT.
  - Events 01 and 10 are ignored here.
- Abort:
  - Bus abort, or an accepted event 11, in ARMED or POST returns the block to IDLE.
  - Nothing is output.
  - The sample carrying event 11 is not stored.
- READOUT:
  - Read `total` words starting at `rd_start`, with the address wrapping modulo depth.
  - The RAM has synchronous read (1-cycle latency). Reads are prefetched so that the output sustains 1 sample per cycle while `sto_tready` = 1.
  - `sto_tlast` = 1 only on word number `total`.
  - The transfer with `tlast` returns the block to IDLE.
  - Abort and arm are ignored in READOUT.
- Simultaneous events:
  - Bus arm and event 01 in the same cycle: a single arm.
  - Bus abort and an event 10 sample in the same cycle: abort wins.
  - `cfg_*` writes during a capture take effect only at the next trigger latch; values already latched are unaffected.

## Timing

- Reset values: `sts_state` = IDLE, `sto_tvalid` = 0, `sto_tlast` = 0, `sto_tdata` = 0, `sti_tready` = 1, `bus_wready` = 1.
- Reset mid-capture or mid-readout: the block is in IDLE the next cycle, all pending output is dropped, and RAM contents are don't-care.
- State transitions take effect on the clock edge of the causing transfer.
- `sti_tready` is 0 starting from the first cycle in READOUT.
- Readout latency:
  - READOUT is entered at edge N.
  - The first RAM read is issued in cycle N.
  - `sto_tvalid` = 1 from cycle N+1 onward (the edge after entry).
- Output handshake:
  - Once asserted, `sto_tvalid`, `sto_tdata` and `sto_tlast` are held stable until `sto_tready`.
  - `sto_tvalid` never drops without a transfer.
- IDLE is reached on the edge of the last transfer; `sti_tready` = 1 in the following cycle.

## Test plan

1. Pre-trigger and post-trigger window.
   - Stimulus: `cfg_pre` = 4, `cfg_post` = 3, bus arm; feed 0x10..0x1F with event 10 on 0x18; `sto_tready` = 1.
   - Required: output 0x14..0x1A (7 samples); `tlast` only on 0x1A; 7 consecutive output cycles.
2. History shorter than `cfg_pre`.
   - Stimulus: `cfg_pre` = 8; arm via event 01 on 0x20; trigger on 0x22; `cfg_post` = 2.
   - Required: output 0x20, 0x21, 0x22, 0x23.
3. Wrap and clip.
   - Stimulus: `MAW` = 4, `cfg_pre` = 10, `cfg_post` = 12; 40 samples before the trigger.
   - Required: exactly 16 samples out, i.e. 10 pre-trigger + 6 post, oldest first; `tlast` on the 16th.
4. Abort.
   - Stimulus: arm; event 11 on sample 5.
   - Required: `sts_state` = 0 on the next cycle; no `sto_tvalid`.
   - Stimulus: bus abort in the same cycle as a trigger sample.
   - Required: IDLE; no output.
5. Output backpressure and stall.
   - Stimulus: toggle `sto_tready` 1-0-0-1 during readout.
   - Required: data is held while stalled; no sample is lost or duplicated; `sti_tready` = 0 throughout READOUT.
   - Stimulus: `rst` asserted mid-readout.
   - Required: `sto_tvalid` = 0 and `sts_state` = 0 on the next cycle.
